// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-requester memory arbiter:
// FSM state encoding and requester index constants.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

    localparam logic REQ_M0 = 1'b0;
    localparam logic REQ_M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports and the memory port of mem_arbiter.
// slave  = arbiter view, master = view of the surrounding caches/memory.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  m0_cs, m0_we, m0_ack, m0_stall, m0_err;
    logic [ADDR_WIDTH-1:0] m0_addr;
    logic [DATA_WIDTH-1:0] m0_din, m0_dout;
    logic                  m1_cs, m1_we, m1_ack, m1_stall, m1_err;
    logic [ADDR_WIDTH-1:0] m1_addr;
    logic [DATA_WIDTH-1:0] m1_din, m1_dout;
    logic                  mem_cs, mem_we, mem_ack;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_din, mem_dout;

    modport slave (
        input  m0_cs, m0_we, m0_addr, m0_din,
        input  m1_cs, m1_we, m1_addr, m1_din,
        input  mem_dout, mem_ack,
        output m0_dout, m0_ack, m0_stall, m0_err,
        output m1_dout, m1_ack, m1_stall, m1_err,
        output mem_cs, mem_we, mem_addr, mem_din
    );

    modport master (
        output m0_cs, m0_we, m0_addr, m0_din,
        output m1_cs, m1_we, m1_addr, m1_din,
        output mem_dout, mem_ack,
        input  m0_dout, m0_ack, m0_stall, m0_err,
        input  m1_dout, m1_ack, m1_stall, m1_err,
        input  mem_cs, mem_we, mem_addr, mem_din
    );
endinterface

// File: rtl/mem_arb_rr.sv
// Combinational two-way round-robin picker: a lone requester wins,
// on contention the requester that was not granted last wins.
module mem_arb_rr
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant
);
    assign grant_valid = |req;

    // pick the winner index
    always_comb begin
        grant = REQ_M0;
        if (req == 2'b11)
            grant = ~last_grant;
        else if (req[1])
            grant = REQ_M1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one slow word memory between two requesters.
// IDLE picks a winner and latches its request, BUSY holds the memory
// address stable until mem_ack, RELEASE pulses the granted ack.
// Optional feature: define MEM_ARB_TIMEOUT_EN to abort an access after
// TIMEOUT_CYCLES BUSY cycles with the granted err flag set.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input logic          clk,
    input logic          rst,
    mem_arbiter_if.slave bus
);
    state_t state, state_nxt;
    logic   grant, last_grant;
    logic   rr_valid, rr_grant;
    logic   timeout, done;

    logic [1:0]                 ack_q, err_q;
    logic [1:0][DATA_WIDTH-1:0] dout_q;
    logic                       we_q;
    logic [ADDR_WIDTH-1:0]      addr_q;
    logic [DATA_WIDTH-1:0]      din_q;

    mem_arb_rr u_rr (
        .req         ({bus.m1_cs, bus.m0_cs}),
        .last_grant  (last_grant),
        .grant_valid (rr_valid),
        .grant       (rr_grant)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [CNT_W-1:0] to_cnt;

    // count BUSY cycles; IDLE always precedes BUSY so clearing there
    // gives a fresh count on every entry
    always_ff @(posedge clk) begin
        if (!rst)
            to_cnt <= '0;
        else if (state == BUSY)
            to_cnt <= to_cnt + 1'b1;
        else
            to_cnt <= '0;
    end

    assign timeout = (state == BUSY) && !bus.mem_ack &&
                     (to_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    // access finishes on memory completion or abort
    assign done = (state == BUSY) && (bus.mem_ack || timeout);

    // state register
    always_ff @(posedge clk) begin
        if (!rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rr_valid) state_nxt = BUSY;
            BUSY:    if (done)     state_nxt = RELEASE;
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // request latch, grant bookkeeping and registered responses;
    // responses live for one cycle so the non-granted side stays 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant      <= REQ_M0;
            last_grant <= REQ_M1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            din_q      <= '0;
            ack_q      <= '0;
            err_q      <= '0;
            dout_q     <= '0;
        end else begin
            ack_q  <= '0;
            err_q  <= '0;
            dout_q <= '0;
            if (state == IDLE && rr_valid) begin
                grant  <= rr_grant;
                we_q   <= rr_grant ? bus.m1_we   : bus.m0_we;
                addr_q <= rr_grant ? bus.m1_addr : bus.m0_addr;
                din_q  <= rr_grant ? bus.m1_din  : bus.m0_din;
            end
            if (done) begin
                last_grant    <= grant;
                ack_q[grant]  <= 1'b1;
                err_q[grant]  <= timeout;
                dout_q[grant] <= (timeout || we_q) ? '0 : bus.mem_dout;
            end
        end
    end

    assign bus.mem_cs   = (state == BUSY);
    assign bus.mem_we   = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_din  = din_q;

    assign bus.m0_ack   = ack_q[0];
    assign bus.m1_ack   = ack_q[1];
    assign bus.m0_err   = err_q[0];
    assign bus.m1_err   = err_q[1];
    assign bus.m0_dout  = dout_q[0];
    assign bus.m1_dout  = dout_q[1];
    assign bus.m0_stall = bus.m0_cs & ~bus.m0_ack;
    assign bus.m1_stall = bus.m1_cs & ~bus.m1_ack;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with an 8-cycle word memory model
// (data[i]=i). Build with MEM_ARB_TIMEOUT_EN to add the timeout step.
module tb_mem_arbiter;
    localparam int DELAY = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   n;
    bit   mem_on = 1'b1;
    bit   minit = 1'b0;
    bit   saw_ack;
    logic [31:0] mem [0:15];
    int   mcnt = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // memory model: acks DELAY cycles after mem_cs rises, count restarts when cs drops
    always @(posedge clk) begin
        if (!minit) begin
            for (int i = 0; i < 16; i++) mem[i] <= i;
            minit <= 1'b1;
        end
        if (!bus.mem_cs) begin
            mcnt        <= 0;
            bus.mem_ack <= 1'b0;
        end else begin
            mcnt        <= mcnt + 1;
            bus.mem_ack <= mem_on && (mcnt == DELAY - 1);
            if (mem_on && mcnt == DELAY - 1) begin
                if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_din;
                else            bus.mem_dout <= mem[bus.mem_addr[3:0]];
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // advance until either ack is seen, bounded
    task automatic wait_ack(output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (!(bus.m0_ack || bus.m1_ack) && cnt < 40);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.m0_cs = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_din = 0;
        bus.m1_cs = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_din = 0;
        bus.mem_ack = 0; bus.mem_dout = 0;
        rst = 0;
        tick(); tick();
        chk("rst_mem_cs",   32'(bus.mem_cs), 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_acks",     32'({bus.m0_ack, bus.m1_ack, bus.m0_err, bus.m1_err}), 0);
        chk("rst_dout",     bus.m0_dout | bus.m1_dout, 0);
        rst = 1;
        tick();

        // single read of addr 5 by m0
        bus.m0_cs = 1; bus.m0_we = 0; bus.m0_addr = 5;
        tick();
        chk("rd_mem_cs",   32'(bus.mem_cs), 1);
        chk("rd_mem_addr", bus.mem_addr, 5);
        chk("rd_stall",    32'(bus.m0_stall), 1);
        wait_ack(n);
        chk("rd_latency",  n, DELAY + 1);
        chk("rd_m0_ack",   32'(bus.m0_ack), 1);
        chk("rd_m0_dout",  bus.m0_dout, 5);
        chk("rd_m0_err",   32'(bus.m0_err), 0);
        chk("rd_m0_stall", 32'(bus.m0_stall), 0);
        chk("rd_m1_quiet", 32'({bus.m1_ack, bus.m1_err}) | bus.m1_dout, 0);
        chk("rd_rel_cs",   32'(bus.mem_cs), 0);
        bus.m0_cs = 0;
        tick();
        chk("rd_ack_once", 32'(bus.m0_ack), 0);

        // m1 writes 0xDEADBEEF to addr 3, then renews cs as a read
        bus.m1_cs = 1; bus.m1_we = 1; bus.m1_addr = 3; bus.m1_din = 32'hDEADBEEF;
        tick();
        chk("wr_mem_we",   32'(bus.mem_we), 1);
        chk("wr_mem_din",  bus.mem_din, 32'hDEADBEEF);
        wait_ack(n);
        chk("wr_latency",  n, DELAY + 1);
        chk("wr_m1_ack",   32'(bus.m1_ack), 1);
        chk("wr_m1_dout",  bus.m1_dout, 0);
        chk("wr_m0_ack",   32'(bus.m0_ack), 0);
        bus.m1_we = 0;
        tick();
        chk("wr_ack_once", 32'(bus.m1_ack), 0);
        tick();
        wait_ack(n);
        chk("rb_latency",  n, DELAY + 1);
        chk("rb_m1_ack",   32'(bus.m1_ack), 1);
        chk("rb_m1_dout",  bus.m1_dout, 32'hDEADBEEF);
        bus.m1_cs = 0;
        tick();

        // contention right after reset: m0 first, then strict alternation
        rst = 0; tick(); rst = 1;
        bus.m0_cs = 1; bus.m0_addr = 1;
        bus.m1_cs = 1; bus.m1_addr = 2;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("ct_mem_addr", bus.mem_addr, (k % 2 == 0) ? 1 : 2);
            wait_ack(n);
            chk("ct_latency",  n, DELAY + 1);
            chk("ct_acks",     32'({bus.m1_ack, bus.m0_ack}), (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("ct_dout",     (k % 2 == 0) ? bus.m0_dout : bus.m1_dout, (k % 2 == 0) ? 1 : 2);
            tick();
        end
        bus.m0_cs = 0; bus.m1_cs = 0;
        tick();

        // address held while m0 changes its addr mid-access
        bus.m0_cs = 1; bus.m0_addr = 7;
        tick(); tick(); tick();
        bus.m0_addr = 9;
        tick();
        chk("as_mem_addr", bus.mem_addr, 7);
        wait_ack(n);
        chk("as_latency",  n, DELAY + 1 - 3);
        chk("as_m0_dout",  bus.m0_dout, 7);
        bus.m0_cs = 0;
        tick();

        // reset four cycles into BUSY aborts silently
        bus.m0_cs = 1; bus.m0_addr = 4;
        tick();
        tick(); tick(); tick(); tick();
        rst = 0;
        tick();
        chk("ra_mem_cs",   32'(bus.mem_cs), 0);
        chk("ra_m0_ack",   32'(bus.m0_ack), 0);
        chk("ra_mem_addr", bus.mem_addr, 0);
        rst = 1; bus.m0_cs = 0;
        saw_ack = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.m0_ack || bus.m1_ack) saw_ack = 1;
        end
        chk("ra_no_ack",   32'(saw_ack), 0);
        bus.m0_cs = 1; bus.m0_addr = 6;
        tick();
        wait_ack(n);
        chk("ra_latency",  n, DELAY + 1);
        chk("ra_m0_dout",  bus.m0_dout, 6);
        bus.m0_cs = 0;
        tick();

`ifdef MEM_ARB_TIMEOUT_EN
        // memory never answers: abort after 16 BUSY cycles
        mem_on = 0;
        bus.m0_cs = 1; bus.m0_addr = 2;
        tick();
        wait_ack(n);
        chk("to_latency",  n, 16);
        chk("to_m0_ack",   32'(bus.m0_ack), 1);
        chk("to_m0_err",   32'(bus.m0_err), 1);
        chk("to_m0_dout",  bus.m0_dout, 0);
        chk("to_m1_err",   32'(bus.m1_err), 0);
        bus.m0_cs = 0;
        tick();
        chk("to_idle_cs",  32'(bus.mem_cs), 0);
        chk("to_ack_once", 32'(bus.m0_ack), 0);
        mem_on = 1;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
